move_controller: RTL and testbench

Owns the tic-tac-toe board register and is the writer side of the 18-bit grid bus that the win checker reads. It accepts one cell index per move from the input front end, validates it, writes the current player's mark, and alternates turns. It waits one cycle for the checker's verdict after every write and freezes the board when the game ends.

---
 rtl/tictactoe_pkg.sv | 26 ++
 rtl/turn_timer.sv | 29 ++
 rtl/move_controller.sv | 139 +++++++++++++
 tb/tb_move_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// Shared encodings for the tic-tac-toe board, results and move-controller FSM.
package tictactoe_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned GRID_W    = 2 * NUM_CELLS;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_O     = 2'd1;
  localparam logic [1:0] CELL_X     = 2'd2;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  typedef enum logic [1:0] {StIdle, StWaitMove, StCheck, StOver} state_e;

  // Out-of-range indices read as empty; callers range-check separately.
  function automatic logic [1:0] cell_at(input logic [GRID_W-1:0] g, input logic [3:0] idx);
    cell_at = CELL_EMPTY;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx == 4'(i)) cell_at = g[2*i +: 2];
    end
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn cycle counter; flags expiry once the count reaches TIMEOUT_CYCLES-1.
module turn_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  output logic expired
);

  logic [31:0] count_q, count_d;
  logic        at_limit;

  assign at_limit = (count_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear)          count_d = '0;
    else if (!at_limit) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign expired = !clear && at_limit;

endmodule

// File: rtl/move_controller.sv
// Board owner for tic-tac-toe: validates moves, writes marks, alternates turns and
// latches the checker verdict. Define TURN_TIMEOUT_EN to enable per-turn forfeit.
module move_controller
  import tictactoe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              move_valid,
  input  logic [3:0]        move_pos,
  input  logic [1:0]        winner,
  input  logic              end_signal,
  output logic [GRID_W-1:0] grid,
  output logic              move_ready,
  output logic              move_accept,
  output logic              move_reject,
  output logic              turn,
  output logic [3:0]        move_count,
  output logic              game_over,
  output logic [1:0]        result
);

  state_e            state_q, state_d;
  logic [GRID_W-1:0] grid_q, grid_d;
  logic              turn_q, turn_d;
  logic [3:0]        count_q, count_d;
  logic [1:0]        result_q, result_d;
  logic              accept_q, accept_d;
  logic              reject_q, reject_d;
  logic              legal;
  logic              expired;
  logic [1:0]        mark;

  assign legal = move_valid && (move_pos < 4'(NUM_CELLS)) &&
                 (cell_at(grid_q, move_pos) == CELL_EMPTY);
  assign mark  = turn_q ? CELL_X : CELL_O;

`ifdef TURN_TIMEOUT_EN
  turn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_turn_timer (
    .clock  (clock),
    .resetn (resetn),
    .clear  (start || (state_q != StWaitMove)),
    .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired        = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StWaitMove;
    end else begin
      unique case (state_q)
        StIdle:     state_d = StIdle;
        StWaitMove: begin
          // A legal move on the expiry cycle beats the forfeit.
          if (legal)        state_d = StCheck;
          else if (expired) state_d = StOver;
        end
        StCheck:    state_d = end_signal ? StOver : StWaitMove;
        StOver:     state_d = StOver;
        default:    state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    move_ready = (state_q == StWaitMove);
    game_over  = (state_q == StOver);
  end

  always_comb begin
    grid_d   = grid_q;
    turn_d   = turn_q;
    count_d  = count_q;
    result_d = result_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    if (start) begin
      grid_d   = '0;
      turn_d   = 1'b0;
      count_d  = '0;
      result_d = RES_NONE;
    end else if (state_q == StWaitMove) begin
      if (legal) begin
        for (int i = 0; i < NUM_CELLS; i++) begin
          if (move_pos == 4'(i)) grid_d[2*i +: 2] = mark;
        end
        if (count_q != 4'(NUM_CELLS)) count_d = count_q + 4'd1;
        accept_d = 1'b1;
      end else if (expired) begin
        result_d = turn_q ? RES_P1 : RES_P2;
      end else if (move_valid) begin
        reject_d = 1'b1;
      end
    end else if (state_q == StCheck) begin
      if (end_signal) result_d = winner;
      else            turn_d   = !turn_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      grid_q   <= '0;
      turn_q   <= 1'b0;
      count_q  <= '0;
      result_q <= RES_NONE;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      grid_q   <= grid_d;
      turn_q   <= turn_d;
      count_q  <= count_d;
      result_q <= result_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
    end
  end

  assign grid        = grid_q;
  assign turn        = turn_q;
  assign move_count  = count_q;
  assign result      = result_q;
  assign move_accept = accept_q;
  assign move_reject = reject_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller with a behavioural win checker and a pulse scoreboard.
module tb_move_controller;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        move_valid;
  logic [3:0]  move_pos;
  logic [1:0]  winner;
  logic        end_signal;
  logic [17:0] grid;
  logic        move_ready;
  logic        move_accept;
  logic        move_reject;
  logic        turn;
  logic [3:0]  move_count;
  logic        game_over;
  logic [1:0]  result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          acc;
    logic [17:0] grid;
  } exp_t;
  exp_t exp_q[$];

  logic [17:0] m_grid;
  bit          m_turn;
  int          m_count;

  localparam int LN [24] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0, 3, 6, 1, 4, 7, 2, 5, 8,
                             0, 4, 8, 2, 4, 6};

  move_controller #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .move_valid (move_valid),
    .move_pos   (move_pos),
    .winner     (winner),
    .end_signal (end_signal),
    .grid       (grid),
    .move_ready (move_ready),
    .move_accept(move_accept),
    .move_reject(move_reject),
    .turn       (turn),
    .move_count (move_count),
    .game_over  (game_over),
    .result     (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [1:0] judge(input logic [17:0] g);
    logic [1:0] a, b, c, res;
    bit         full;
    res  = 2'b00;
    full = 1'b1;
    for (int i = 0; i < 9; i++) if (g[2*i +: 2] == 2'd0) full = 1'b0;
    for (int l = 0; l < 8; l++) begin
      a = g[2*LN[3*l] +: 2];
      b = g[2*LN[3*l+1] +: 2];
      c = g[2*LN[3*l+2] +: 2];
      if (a != 2'd0 && a == b && b == c) res = a;
    end
    if (res == 2'b00 && full) res = 2'b11;
    return res;
  endfunction

  // Combinational win checker stand-in, reading the DUT board.
  always_comb begin
    winner     = judge(grid);
    end_signal = (winner != 2'b00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (move_accept || move_reject) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {move_accept, move_reject}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", {move_accept, move_reject}, e.acc ? 2'b10 : 2'b01);
        chk("pulse_grid", grid, e.grid);
      end
    end
  end

  task automatic new_game();
    start = 1'b1;
    @(negedge clock); #1;
    start   = 1'b0;
    m_grid  = '0;
    m_turn  = 1'b0;
    m_count = 0;
    chk("start_ready", move_ready, 1'b1);
    chk("start_grid", grid, 18'h0);
    chk("start_result", result, 2'b00);
    chk("start_count", move_count, 4'd0);
    chk("start_turn", turn, 1'b0);
  endtask

  task automatic play(input logic [3:0] pos);
    bit         ok;
    logic [1:0] v;
    exp_t       e;
    ok = 1'b0;
    if (pos < 4'd9) ok = (m_grid[2*pos +: 2] == 2'd0);
    if (ok) begin
      m_grid[2*pos +: 2] = m_turn ? 2'd2 : 2'd1;
      m_count++;
    end
    e.acc  = ok;
    e.grid = m_grid;
    exp_q.push_back(e);
    move_pos   = pos;
    move_valid = 1'b1;
    @(negedge clock); #1;
    move_valid = 1'b0;
    chk("pulse_consumed", exp_q.size(), 0);
    if (ok) begin
      chk("ready_low_in_check", move_ready, 1'b0);
      @(negedge clock); #1;
      v = judge(m_grid);
      chk("move_count", move_count, m_count);
      if (v != 2'b00) begin
        chk("game_over", game_over, 1'b1);
        chk("result", result, v);
      end else begin
        m_turn = !m_turn;
        chk("turn", turn, m_turn);
        chk("ready_again", move_ready, 1'b1);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grid"}, grid, 18'h0);
    chk({tag, "_turn"}, turn, 1'b0);
    chk({tag, "_count"}, move_count, 4'd0);
    chk({tag, "_result"}, result, 2'b00);
    chk({tag, "_over"}, game_over, 1'b0);
    chk({tag, "_ready"}, move_ready, 1'b0);
    chk({tag, "_accept"}, move_accept, 1'b0);
    chk({tag, "_reject"}, move_reject, 1'b0);
  endtask

  initial begin
    exp_t e;
    resetn     = 1'b1;
    start      = 1'b0;
    move_valid = 1'b0;
    move_pos   = 4'd0;
    m_grid     = '0;
    m_turn     = 1'b0;
    m_count    = 0;
    #2 resetn = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk_reset_outputs("reset");
    resetn = 1'b1;

    // Requests in IDLE must be ignored.
    move_valid = 1'b1;
    move_pos   = 4'd0;
    repeat (2) @(negedge clock);
    #1;
    move_valid = 1'b0;
    chk("idle_grid", grid, 18'h0);
    chk("idle_ready", move_ready, 1'b0);

    new_game();
    play(4'd4);
    chk("first_move_grid", grid, 18'h00100);
    chk("first_move_turn", turn, 1'b1);
    play(4'd4);
    play(4'd9);
    chk("reject_grid", grid, 18'h00100);
    chk("reject_turn", turn, 1'b1);

    // Held request on an occupied cell: one reject per cycle.
    e.acc  = 1'b0;
    e.grid = m_grid;
    repeat (3) exp_q.push_back(e);
    move_pos   = 4'd4;
    move_valid = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    move_valid = 1'b0;
    chk("held_rejects", exp_q.size(), 0);
    @(negedge clock); #1;
    chk("held_release", move_reject, 1'b0);

    // O wins on the top row.
    new_game();
    play(4'd0);
    play(4'd3);
    play(4'd1);
    play(4'd4);
    play(4'd2);
    chk("win_over", game_over, 1'b1);
    chk("win_result", result, 2'b01);
    move_pos   = 4'd8;
    move_valid = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    move_valid = 1'b0;
    chk("over_grid_frozen", grid, m_grid);
    chk("over_count_frozen", move_count, 4'd5);
    chk("over_ready", move_ready, 1'b0);

    // Full board with no line.
    new_game();
    play(4'd0);
    play(4'd1);
    play(4'd2);
    play(4'd4);
    play(4'd3);
    play(4'd5);
    play(4'd7);
    play(4'd6);
    play(4'd8);
    chk("draw_result", result, 2'b11);
    chk("draw_count", move_count, 4'd9);
    chk("draw_over", game_over, 1'b1);

    // Asynchronous reset mid-game.
    new_game();
    play(4'd0);
    play(4'd1);
    resetn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clock); #1;
    resetn = 1'b1;
    @(negedge clock); #1;
    chk("after_reset_ready", move_ready, 1'b0);

    // start while in CHECK wins over the verdict.
    new_game();
    e.acc  = 1'b1;
    e.grid = 18'h00001;
    exp_q.push_back(e);
    move_pos   = 4'd0;
    move_valid = 1'b1;
    @(negedge clock); #1;
    move_valid = 1'b0;
    chk("in_check_ready", move_ready, 1'b0);
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    chk("check_start_grid", grid, 18'h0);
    chk("check_start_turn", turn, 1'b0);
    chk("check_start_count", move_count, 4'd0);
    chk("check_start_ready", move_ready, 1'b1);

`ifdef TURN_TIMEOUT_EN
    // Player one idles; forfeit lands eight cycles into the turn.
    new_game();
    repeat (7) @(negedge clock);
    #1;
    chk("timeout_not_yet", game_over, 1'b0);
    @(negedge clock); #1;
    chk("timeout_over", game_over, 1'b1);
    chk("timeout_result", result, 2'b10);
`endif

    @(negedge clock); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
